// File: rtl/gen_barra_pwm.sv
// gen_barra_pwm: bar-graph overlay for one colour-selector nibble.
// It produces {marco, barra, fondo, letra} from the VGA scan position.
// The bar value is latched at frame_start. The fill length is computed
// during vertical blanking by a 12-step restoring divider. The previous
// length stays in use until the new one is ready.
module gen_barra_pwm #(
    parameter int X0        = 100,
    parameter int Y0        = 50,
    parameter int ANCHO     = 204,
    parameter int ALTO      = 40,
    parameter int GROSOR    = 2,
    parameter int VAL_MAX   = 100,
    parameter int TICK_H    = 6,
    parameter int TICK_PASO = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] h_cnt,
    input  logic [10:0] v_cnt,
    input  logic        pixel_valid,
    input  logic        frame_start,
    input  logic [6:0]  valor,
    input  logic        valor_valid,
    output logic [3:0]  pixel_info,
    output logic        busy
);

    localparam int ANCHO_INT = ANCHO - 2 * GROSOR;

    // Geometry as 11-bit unsigned bounds (all pixel compares are 11-bit)
    localparam logic [10:0] X_INI   = 11'(X0);
    localparam logic [10:0] X_FIN   = 11'(X0 + ANCHO);
    localparam logic [10:0] X_BI    = 11'(X0 + GROSOR);
    localparam logic [10:0] X_BD    = 11'(X0 + ANCHO - GROSOR);
    localparam logic [10:0] Y_INI   = 11'(Y0);
    localparam logic [10:0] Y_FIN   = 11'(Y0 + ALTO);
    localparam logic [10:0] Y_BI    = 11'(Y0 + GROSOR);
    localparam logic [10:0] Y_BD    = 11'(Y0 + ALTO - GROSOR);
    localparam logic [10:0] Y_TI    = 11'(Y0 + ALTO + 2);
    localparam logic [10:0] Y_TF    = 11'(Y0 + ALTO + 2 + TICK_H);
    localparam logic [10:0] A_INT   = 11'(ANCHO_INT);
    localparam logic [10:0] PASO_M1 = 11'(TICK_PASO - 1);

    // Divider constants; VAL_MAX < 128 keeps the remainder in 7 bits
    localparam logic [14:0] PROD_K  = 15'(ANCHO_INT);
    localparam logic [6:0]  VMAX7   = 7'(VAL_MAX);
    localparam logic [7:0]  DIV8    = 8'(VAL_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } estado_t;

    estado_t     state_r;
    estado_t     state_nx_s;
    logic [6:0]  shadow_r;
    logic [6:0]  active_r;
    logic [14:0] prod_r;       // [11:0] holds dividend bits, then quotient bits
    logic [6:0]  rem_r;
    logic [3:0]  step_r;
    logic [10:0] len_r;
    logic [10:0] tick_cnt_r;

    logic [14:0] prod_s;
    logic [7:0]  trial_s;
    logic        ge_s;
    logic [6:0]  rem_nx_s;
    logic [10:0] x_rel_s;
    logic        in_frame_s;
    logic        in_inner_s;
    logic        in_tick_s;
    logic [10:0] tick_mod_s;
    logic [3:0]  pix_s;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state; a frame_start while computing restarts the load
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) state_nx_s = ST_LOAD;
                else             state_nx_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (frame_start) state_nx_s = ST_LOAD;
                else             state_nx_s = ST_CALC;
            end
            ST_CALC: begin
                if (frame_start)          state_nx_s = ST_LOAD;
                else if (step_r == 4'd11) state_nx_s = ST_DONE;
                else                      state_nx_s = ST_CALC;
            end
            ST_DONE: begin
                if (frame_start) state_nx_s = ST_LOAD;
                else             state_nx_s = ST_IDLE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Divider step: product setup and one restoring-division trial
    always_comb begin
        prod_s  = {8'd0, active_r} * PROD_K;
        trial_s = {rem_r, prod_r[11]};
        ge_s    = (trial_s >= DIV8);
        if (ge_s) begin
            rem_nx_s = 7'(trial_s - DIV8);
        end else begin
            rem_nx_s = trial_s[6:0];
        end
    end

    // Shadow value capture, saturated to full scale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= 7'd0;
        end else if (valor_valid) begin
            shadow_r <= (valor > VMAX7) ? VMAX7 : valor;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Divider datapath and double-buffered fill length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r <= 7'd0;
            prod_r   <= 15'd0;
            rem_r    <= 7'd0;
            step_r   <= 4'd0;
            len_r    <= 11'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (frame_start) active_r <= shadow_r;
                end
                ST_LOAD: begin
                    if (frame_start) begin
                        active_r <= shadow_r;
                    end else begin
                        // Top 3 bits are below VAL_MAX, so they seed the remainder
                        prod_r <= prod_s;
                        rem_r  <= {4'd0, prod_s[14:12]};
                        step_r <= 4'd0;
                    end
                end
                ST_CALC: begin
                    if (frame_start) begin
                        active_r <= shadow_r;
                    end else begin
                        rem_r  <= rem_nx_s;
                        prod_r <= {prod_r[14:12], prod_r[10:0], ge_s};
                        step_r <= step_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    len_r <= prod_r[10:0];
                    if (frame_start) active_r <= shadow_r;
                end
                default: begin
                    active_r <= active_r;
                end
            endcase
        end
    end

    // Busy flag follows the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_nx_s != ST_IDLE);
        end
    end

    // Pixel classification; tick modulo comes from the per-line counter
    always_comb begin
        x_rel_s    = h_cnt - X_BI;
        in_frame_s = (h_cnt >= X_INI) && (h_cnt < X_FIN) &&
                     (v_cnt >= Y_INI) && (v_cnt < Y_FIN);
        in_inner_s = (h_cnt >= X_BI) && (h_cnt < X_BD) &&
                     (v_cnt >= Y_BI) && (v_cnt < Y_BD);
        in_tick_s  = (v_cnt >= Y_TI) && (v_cnt < Y_TF) && (x_rel_s <= A_INT);
        if (x_rel_s == 11'd0) begin
            tick_mod_s = 11'd0;
        end else begin
            tick_mod_s = tick_cnt_r;
        end
        pix_s = 4'b0000;
        if (!pixel_valid) begin
            pix_s = 4'b0000;
        end else if (in_frame_s && !in_inner_s) begin
            pix_s = 4'b1000;
        end else if (in_inner_s) begin
            if (x_rel_s < len_r) pix_s = 4'b0100;
            else                 pix_s = 4'b0010;
        end else if (in_tick_s) begin
            if (tick_mod_s == 11'd0) pix_s = 4'b0001;
            else                     pix_s = 4'b0000;
        end else begin
            pix_s = 4'b0000;
        end
    end

    // Tick position counter: restarts at x_rel=0, wraps at TICK_PASO-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= 11'd0;
        end else if (tick_mod_s == PASO_M1) begin
            tick_cnt_r <= 11'd0;
        end else begin
            tick_cnt_r <= tick_mod_s + 11'd1;
        end
    end

    // Registered pixel output (one cycle of latency)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_info <= 4'b0000;
        end else begin
            pixel_info <= pix_s;
        end
    end

endmodule

// File: tb/tb_gen_barra_pwm.sv
// Bench for gen_barra_pwm: directed vectors with literal expectations plus a
// frame-level behavioural model compared on every negative clock edge.
module tb_gen_barra_pwm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] h_cnt = 11'd0;
    logic [10:0] v_cnt = 11'd0;
    logic        pixel_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [6:0]  valor = 7'd0;
    logic        valor_valid = 1'b0;
    logic [3:0]  pixel_info;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    gen_barra_pwm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .pixel_valid (pixel_valid),
        .frame_start (frame_start),
        .valor       (valor),
        .valor_valid (valor_valid),
        .pixel_info  (pixel_info),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int         m_shadow, m_len, m_cnt, m_tgt;
    logic [3:0] exp_pix;
    logic       exp_busy;

    function automatic logic [3:0] classify(int h, int v, bit pv, int ln);
        if (!pv) return 4'b0000;
        if (h >= 100 && h < 304 && v >= 50 && v < 90) begin
            if (h < 102 || h >= 302 || v < 52 || v >= 88) return 4'b1000;
            return ((h - 102) < ln) ? 4'b0100 : 4'b0010;
        end
        if (v >= 92 && v < 98 && h >= 102 && h <= 302)
            return (((h - 102) % 20) == 0) ? 4'b0001 : 4'b0000;
        return 4'b0000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_shadow <= 0;
            m_len    <= 0;
            m_cnt    <= 0;
            m_tgt    <= 0;
            exp_pix  <= 4'b0000;
            exp_busy <= 1'b0;
        end else begin
            exp_pix <= classify(int'(h_cnt), int'(v_cnt), pixel_valid, m_len);
            if (m_cnt == 1) m_len <= m_tgt;
            if (frame_start) begin
                m_cnt <= 14;
                m_tgt <= (m_shadow * 200) / 100;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
            end
            if (valor_valid) m_shadow <= (int'(valor) > 100) ? 100 : int'(valor);
            exp_busy <= frame_start || (m_cnt > 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_chk++;
            if (pixel_info !== exp_pix) begin
                n_err++;
                $display("FAIL model_pix t=%0t h=%0d v=%0d: got %b expected %b",
                         $time, h_cnt, v_cnt, pixel_info, exp_pix);
            end
            n_chk++;
            if (busy !== exp_busy) begin
                n_err++;
                $display("FAIL model_busy t=%0t: got %b expected %b", $time, busy, exp_busy);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string name, input int h, input int v, input logic [3:0] exp);
        h_cnt = 11'(h);
        v_cnt = 11'(v);
        pixel_valid = 1'b1;
        tick();
        chk(name, {28'd0, pixel_info}, {28'd0, exp});
    endtask

    task automatic set_valor(input int val);
        valor = 7'(val);
        valor_valid = 1'b1;
        tick();
        valor_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Pulse frame_start and count edges until busy drops (expect 14)
    task automatic run_frame(input string name);
        int k;
        pulse_frame();
        chk({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
        k = 1;
        while (k <= 40) begin
            tick();
            if (!busy) break;
            k++;
        end
        chk({name, "_latency"}, k, 32'd14);
    endtask

    // Sweep rows of the tick strip with consecutive h; return letra count
    task automatic sweep(input int v0, input int v1, input bit pv, output int n_letra, output int n_other);
        n_letra = 0;
        n_other = 0;
        for (int v = v0; v <= v1; v++) begin
            for (int h = 95; h <= 310; h++) begin
                h_cnt = 11'(h);
                v_cnt = 11'(v);
                pixel_valid = pv;
                tick();
                if (pixel_info == 4'b0001) n_letra++;
                else if (pixel_info != 4'b0000) n_other++;
            end
        end
    endtask

    int nl, no;

    initial begin
        #1 rst_n = 1'b0;
        #10;
        chk_en = 1'b1;
        chk("reset_pix", {28'd0, pixel_info}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // T1: value 50 -> len 100
        set_valor(50);
        run_frame("t1");
        probe("t1_barra_201", 201, 70, 4'b0100);
        probe("t1_fondo_202", 202, 70, 4'b0010);

        // T2: frame corners and outside
        probe("t2_marco_100_50", 100, 50, 4'b1000);
        probe("t2_marco_303_89", 303, 89, 4'b1000);
        probe("t2_marco_101_60", 101, 60, 4'b1000);
        probe("t2_out_99", 99, 70, 4'b0000);
        probe("t2_out_304", 304, 70, 4'b0000);

        // T3: saturation and zero
        set_valor(127);
        run_frame("t3a");
        probe("t3_full_301", 301, 70, 4'b0100);
        probe("t3_border_302", 302, 70, 4'b1000);
        set_valor(0);
        run_frame("t3b");
        probe("t3_zero_102", 102, 70, 4'b0010);

        // T4: mid-frame update held until next calculation
        set_valor(50);
        run_frame("t4a");
        set_valor(80);
        probe("t4_hold_201", 201, 70, 4'b0100);
        probe("t4_hold_261", 261, 70, 4'b0010);
        pulse_frame();
        repeat (12) tick();
        chk("t4_old_len", {28'd0, pixel_info}, 32'h2);
        repeat (3) tick();
        chk("t4_new_len", {28'd0, pixel_info}, 32'h4);
        chk("t4_busy_low", {31'd0, busy}, 32'd0);
        probe("t4_fondo_262", 262, 70, 4'b0010);

        // T5: restart inside CALC, then reset mid-calculation
        set_valor(30);
        pulse_frame();
        repeat (6) tick();
        set_valor(90);
        chk("t5_busy_mid", {31'd0, busy}, 32'd1);
        run_frame("t5");
        probe("t5_barra_281", 281, 70, 4'b0100);
        probe("t5_fondo_282", 282, 70, 4'b0010);
        h_cnt = 11'd150;
        v_cnt = 11'd70;
        pulse_frame();
        repeat (6) tick();
        chk("t5_pre_rst_pix", {28'd0, pixel_info}, 32'h4);
        chk("t5_pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_pix", {28'd0, pixel_info}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        probe("t5_len0_102", 102, 70, 4'b0010);
        probe("t5_len0_150", 150, 70, 4'b0010);

        // T6: tick strip
        set_valor(50);
        run_frame("t6");
        sweep(92, 97, 1'b1, nl, no);
        chk("t6_letra_count", nl, 32'd66);
        chk("t6_other_count", no, 32'd0);
        sweep(91, 91, 1'b1, nl, no);
        chk("t6_row91_letra", nl, 32'd0);
        sweep(94, 94, 1'b0, nl, no);
        chk("t6_pv0_letra", nl, 32'd0);
        chk("t6_pv0_other", no, 32'd0);
        sweep(70, 70, 1'b0, nl, no);
        chk("t6_pv0_frame", no, 32'd0);

        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
